fifo_sync_fwft: RTL and testbench
=================================

FIFO_SYNC_FWFT -- requirements
Module: fifo_sync_fwft

Interface
REQ-001 Parameter DEPTH, 16, entry count; power of 2, range 4..1024.
REQ-002 Parameter WIDTH, 32, data bits per entry; range 1..256.
REQ-003 Parameter AFULL_LVL, DEPTH-2, occupancy at or above which o_afull asserts; range 1..DEPTH.
REQ-004 Parameter AEMPTY_LVL, 2, occupancy at or below which o_aempty asserts; range 0..DEPTH-1.
REQ-005 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-006 i_clk_rst  input  1  reset, asynchronous assert, active-high.
REQ-007 i_wdata_vld  input  1  write request.
REQ-008 i_wdata  input  WIDTH  write data.
REQ-009 o_wdata_rdy  output  1  FIFO can accept a write this cycle.
REQ-010 o_rdata_vld  output  1  o_rdata holds the head entry.
REQ-011 o_rdata  output  WIDTH  head entry (first-word-fall-through).
REQ-012 i_rdata_rdy  input  1  consumer pops head this cycle.
REQ-013 o_level  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 o_full, o_afull, o_empty, o_aempty  output  1 each  occupancy flags.
REQ-015 o_ovf  output  1  sticky: a write was dropped.
REQ-016 o_drop_cnt  output  16  saturating count of dropped writes.
REQ-017 i_clr_flags  input  1  clears o_ovf and o_drop_cnt.

Function
REQ-018 Write accepted iff i_wdata_vld && o_wdata_rdy; o_wdata_rdy = !o_full, from registered state only.
REQ-019 Read handshake iff o_rdata_vld && i_rdata_rdy; o_rdata_vld = !o_empty.
REQ-020 Write-to-read latency: word accepted at edge N into empty FIFO appears with o_rdata_vld=1 after edge N (1 cycle).
REQ-021 After a pop, next entry (if any) is presented after the same edge; back-to-back pops sustain 1 word/cycle.
REQ-022 Write while full (including same-cycle pop): write dropped, not stored; o_ovf set; o_drop_cnt +1, saturating at 0xFFFF.
REQ-023 Write and pop same cycle, neither full nor empty: both occur; o_level unchanged.
REQ-024 o_level +1 on write-only, -1 on pop-only; never exceeds DEPTH, never underflows.
REQ-025 Pointers carry one extra wrap bit; wrap from DEPTH-1 to 0 seamless, data order preserved.
REQ-026 o_full = (o_level==DEPTH); o_empty = (o_level==0); o_afull = (o_level>=AFULL_LVL); o_aempty = (o_level<=AEMPTY_LVL); all decoded from registers, no extra latency.
REQ-027 i_clr_flags with a drop in the same cycle: clear applies first, result o_ovf=1, o_drop_cnt=1.
REQ-028 o_rdata is don't-care when o_rdata_vld=0; must not be X-checked by bench.

Reset
REQ-029 While i_clk_rst=1: o_wdata_rdy=0, o_rdata_vld=0, o_level=0, o_empty=1, o_aempty=1, o_full=0, o_afull=0, o_ovf=0, o_drop_cnt=0.
REQ-030 First rising edge after deassert: o_wdata_rdy=1.
REQ-031 Reset mid-operation discards all contents; pointers zeroed; storage array not reset.
REQ-032 Writes presented during reset are ignored and not counted as drops.

Structure
REQ-033 Package fifo_pkg holds: level-width function, drop-counter typedef (16-bit), DROP_CNT_MAX constant.
REQ-034 Parameter range checks by elaboration-time assertions in the module.
REQ-035 Sub-module fifo_sync_ram: DEPTH x WIDTH, one synchronous write port, one asynchronous read port.
REQ-036 Single clock domain; no synchronisers.

Verification
REQ-037 Reset, then write 0xA5A5A5A5 once -> o_rdata_vld=1 next cycle, o_rdata=0xA5A5A5A5, o_level=1.
REQ-038 DEPTH=16: write 16 words, no pops -> o_full=1, o_wdata_rdy=0, o_afull from level 14; 17th write -> o_ovf=1, o_drop_cnt=1, contents unchanged.
REQ-039 Continuous write+pop for 40 cycles from level 3 -> o_level stays 3, output sequence equals input sequence across pointer wrap.
REQ-040 Full FIFO, write+pop same cycle -> pop succeeds, write dropped, o_level=15, o_drop_cnt=1.
REQ-041 o_drop_cnt at 0xFFFF plus one drop -> stays 0xFFFF; i_clr_flags with concurrent drop -> o_drop_cnt=1, o_ovf=1.
REQ-042 Assert i_clk_rst asynchronously at level 9 -> outputs take REQ-029 values immediately, no old data after deassert.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the synchronous first-word-fall-through FIFO.
package fifo_pkg;

    localparam int DROP_CNT_W = 16;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    localparam drop_cnt_t DROP_CNT_MAX = '1;

    // Occupancy needs one bit more than the address so that a completely full FIFO is representable.
    function automatic int level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_sync_ram.sv
// DEPTH x WIDTH storage: one synchronous write port, one asynchronous read port.
module fifo_sync_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; the FIFO pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_fwft.sv
// Single-clock FIFO whose head entry is always presented on o_rdata (first-word-fall-through),
// with occupancy flags and a sticky overflow indicator plus saturating drop counter.
module fifo_sync_fwft
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 32,
    parameter int AFULL_LVL  = DEPTH - 2,
    parameter int AEMPTY_LVL = 2
) (
    input  logic                          i_clk,
    input  logic                          i_clk_rst,
    input  logic                          i_wdata_vld,
    input  logic [WIDTH-1:0]              i_wdata,
    output logic                          o_wdata_rdy,
    output logic                          o_rdata_vld,
    output logic [WIDTH-1:0]              o_rdata,
    input  logic                          i_rdata_rdy,
    output logic [level_width(DEPTH)-1:0] o_level,
    output logic                          o_full,
    output logic                          o_afull,
    output logic                          o_empty,
    output logic                          o_aempty,
    output logic                          o_ovf,
    output logic [15:0]                   o_drop_cnt,
    input  logic                          i_clr_flags
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_width(DEPTH);

    if (DEPTH < 4 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fifo_sync_fwft: DEPTH must be a power of 2 in 4..1024");
    end
    if (WIDTH < 1 || WIDTH > 256) begin : g_bad_width
        $error("fifo_sync_fwft: WIDTH must be in 1..256");
    end
    if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
        $error("fifo_sync_fwft: AFULL_LVL must be in 1..DEPTH");
    end
    if (AEMPTY_LVL < 0 || AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_fwft: AEMPTY_LVL must be in 0..DEPTH-1");
    end

    // Pointers carry a wrap bit above the address, so their difference is the occupancy.
    logic [LW-1:0] wr_ptr;
    logic [LW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          rdy_en;
    logic          ovf;
    drop_cnt_t     drop_cnt;

    logic full;
    logic empty;
    logic wr_en;
    logic rd_en;
    logic drop;

    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

    // A write into a full FIFO is dropped even if the head is popped in the same cycle.
    assign wr_en = i_wdata_vld && rdy_en && !full;
    assign rd_en = !empty && i_rdata_rdy;
    assign drop  = i_wdata_vld && full;

    fifo_sync_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (i_clk),
        .we    (wr_en),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (i_wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (o_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_clk_rst) begin
        if (i_clk_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rdy_en   <= 1'b0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (wr_en) begin
                wr_ptr <= wr_ptr + LW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + LW'(1);
            end
            // A clear is applied before a concurrent drop is counted.
            if (i_clr_flags) begin
                ovf      <= drop;
                drop_cnt <= drop ? drop_cnt_t'(1) : '0;
            end else if (drop) begin
                ovf <= 1'b1;
                if (drop_cnt != DROP_CNT_MAX) begin
                    drop_cnt <= drop_cnt + drop_cnt_t'(1);
                end
            end
        end
    end

    assign o_wdata_rdy = rdy_en && !full;
    assign o_rdata_vld = !empty;
    assign o_level     = level;
    assign o_full      = full;
    assign o_empty     = empty;
    assign o_afull     = (level >= LW'(AFULL_LVL));
    assign o_aempty    = (level <= LW'(AEMPTY_LVL));
    assign o_ovf       = ovf;
    assign o_drop_cnt  = drop_cnt;

endmodule

// File: tb/tb_fifo_sync_fwft.sv
// Directed bench for fifo_sync_fwft (DEPTH=16, WIDTH=32, AFULL_LVL=14, AEMPTY_LVL=2).
module tb_fifo_sync_fwft;

    logic        clk = 1'b0;
    logic        rst;
    logic        wvld;
    logic [31:0] wdata;
    logic        wrdy;
    logic        rvld;
    logic [31:0] rdata;
    logic        rrdy;
    logic [4:0]  level;
    logic        full;
    logic        afull;
    logic        empty;
    logic        aempty;
    logic        ovf;
    logic [15:0] drop_cnt;
    logic        clr;

    int checks = 0;
    int errors = 0;

    fifo_sync_fwft #(
        .DEPTH      (16),
        .WIDTH      (32),
        .AFULL_LVL  (14),
        .AEMPTY_LVL (2)
    ) dut (
        .i_clk       (clk),
        .i_clk_rst   (rst),
        .i_wdata_vld (wvld),
        .i_wdata     (wdata),
        .o_wdata_rdy (wrdy),
        .o_rdata_vld (rvld),
        .o_rdata     (rdata),
        .i_rdata_rdy (rrdy),
        .o_level     (level),
        .o_full      (full),
        .o_afull     (afull),
        .o_empty     (empty),
        .o_aempty    (aempty),
        .o_ovf       (ovf),
        .o_drop_cnt  (drop_cnt),
        .i_clr_flags (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_wrdy"},   wrdy,     32'd0);
        check({tag, "_rvld"},   rvld,     32'd0);
        check({tag, "_level"},  level,    32'd0);
        check({tag, "_empty"},  empty,    32'd1);
        check({tag, "_aempty"}, aempty,   32'd1);
        check({tag, "_full"},   full,     32'd0);
        check({tag, "_afull"},  afull,    32'd0);
        check({tag, "_ovf"},    ovf,      32'd0);
        check({tag, "_drop"},   drop_cnt, 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        wvld  = 1'b0;
        wdata = '0;
        rrdy  = 1'b0;
        clr   = 1'b0;
        #3;
        check_reset_state("rst");

        // Writes presented during reset are ignored and never counted as drops.
        wvld  = 1'b1;
        wdata = 32'h1111_1111;
        tick();
        tick();
        check("rst_wr_level", level, 32'd0);
        check("rst_wr_drop", drop_cnt, 32'd0);
        check("rst_wr_wrdy", wrdy, 32'd0);

        wvld = 1'b0;
        rst  = 1'b0;
        check("deassert_wrdy_pre", wrdy, 32'd0);
        tick();
        check("deassert_wrdy_post", wrdy, 32'd1);

        // Single write: visible one edge later.
        wvld  = 1'b1;
        wdata = 32'hA5A5_A5A5;
        tick();
        wvld = 1'b0;
        check("single_rvld", rvld, 32'd1);
        check("single_rdata", rdata, 32'hA5A5_A5A5);
        check("single_level", level, 32'd1);
        check("single_empty", empty, 32'd0);
        rrdy = 1'b1;
        tick();
        rrdy = 1'b0;
        check("single_pop_level", level, 32'd0);
        check("single_pop_rvld", rvld, 32'd0);

        // Fill to full, checking almost-full/almost-empty thresholds on the way.
        for (int i = 0; i < 16; i++) begin
            wvld  = 1'b1;
            wdata = 32'hD000_0000 + i;
            tick();
            check("fill_level", level, i + 1);
            check("fill_afull", afull, (i + 1 >= 14) ? 32'd1 : 32'd0);
            check("fill_aempty", aempty, (i + 1 <= 2) ? 32'd1 : 32'd0);
        end
        wvld = 1'b0;
        check("full_flag", full, 32'd1);
        check("full_wrdy", wrdy, 32'd0);
        check("full_head", rdata, 32'hD000_0000);

        // 17th write is dropped.
        wvld  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        tick();
        wvld = 1'b0;
        check("ovf_flag", ovf, 32'd1);
        check("ovf_drop", drop_cnt, 32'd1);
        check("ovf_level", level, 32'd16);

        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ovf", ovf, 32'd0);
        check("clr_drop", drop_cnt, 32'd0);

        // Full FIFO with simultaneous write and pop: pop wins, write dropped.
        wvld  = 1'b1;
        wdata = 32'hBAD0_0001;
        rrdy  = 1'b1;
        tick();
        wvld = 1'b0;
        rrdy = 1'b0;
        check("fullwp_level", level, 32'd15);
        check("fullwp_drop", drop_cnt, 32'd1);
        check("fullwp_ovf", ovf, 32'd1);

        // Drain: contents must be the original words in order.
        rrdy = 1'b1;
        for (int k = 0; k < 15; k++) begin
            check("drain_rdata", rdata, 32'hD000_0001 + k);
            tick();
        end
        rrdy = 1'b0;
        check("drain_empty", empty, 32'd1);

        // Steady write+pop at level 3 across several pointer wraps.
        for (int i = 0; i < 3; i++) begin
            wvld  = 1'b1;
            wdata = 32'hC000_0000 + i;
            tick();
        end
        check("stream_start_level", level, 32'd3);
        for (int k = 0; k < 40; k++) begin
            wvld  = 1'b1;
            wdata = 32'hC000_0003 + k;
            rrdy  = 1'b1;
            check("stream_rdata", rdata, 32'hC000_0000 + k);
            tick();
            check("stream_level", level, 32'd3);
        end
        wvld = 1'b0;
        for (int j = 0; j < 3; j++) begin
            check("stream_tail", rdata, 32'hC000_0028 + j);
            tick();
        end
        rrdy = 1'b0;
        check("stream_empty", empty, 32'd1);

        // Drop counter saturation.
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wvld  = 1'b1;
            wdata = 32'hF000_0000 + i;
            tick();
        end
        check("sat_full", full, 32'd1);
        wdata = 32'hBAD0_0002;
        for (int i = 0; i < 65535; i++) begin
            tick();
        end
        check("sat_max", drop_cnt, 32'h0000_FFFF);
        tick();
        check("sat_hold", drop_cnt, 32'h0000_FFFF);
        check("sat_ovf", ovf, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        wvld = 1'b0;
        check("clr_drop_same_cycle", drop_cnt, 32'd1);
        check("clr_ovf_same_cycle", ovf, 32'd1);

        // Reduce to level 9 then assert reset asynchronously.
        rrdy = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
        end
        rrdy = 1'b0;
        check("lvl9_level", level, 32'd9);
        check("lvl9_head", rdata, 32'hF000_0007);
        check("lvl9_afull", afull, 32'd0);
        check("lvl9_aempty", aempty, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_wrdy", wrdy, 32'd1);
        check("post_rst_rvld", rvld, 32'd0);
        wvld  = 1'b1;
        wdata = 32'hE000_0001;
        tick();
        wvld = 1'b0;
        check("post_rst_rdata", rdata, 32'hE000_0001);
        check("post_rst_level", level, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
